reg_writeback_unit: RTL

Write-side initiator for the 32x32 integer/float register file. It collects results from the integer datapath and the multi-cycle FPU, arbitrates between them, and buffers them in a small queue. It drives the register file's single write port (`regWrite`, `float`, `writeReg`, `writeData`) at one write per cycle. It also keeps a per-register pending scoreboard so the issue stage can stall on read-after-write hazards until the register file has committed the value.

---
 rtl/reg_writeback_unit_if.sv | 49 ++++
 rtl/reg_writeback_unit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/reg_writeback_unit_if.sv
// Signal bundle between the writeback unit, its two result sources, the
// register file write port and the issue-stage hazard check.
interface reg_writeback_unit_if;
  // integer result source
  logic        intValid;
  logic [4:0]  intDest;
  logic [31:0] intData;
  logic        intReady;
  // FPU result source
  logic        fpValid;
  logic [4:0]  fpDest;
  logic [31:0] fpData;
  logic        fpReady;
  // register file write port
  logic        regWrite;
  logic        float;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  // issue-stage scoreboard access
  logic        issueValid;
  logic [4:0]  issueDest;
  logic        issueFloat;
  logic [4:0]  chkReg1;
  logic [4:0]  chkReg2;
  logic        chkFloat;
  logic        busy;

  modport slave (
    input  intValid, intDest, intData,
    output intReady,
    input  fpValid, fpDest, fpData,
    output fpReady,
    output regWrite, float, writeReg, writeData,
    input  issueValid, issueDest, issueFloat,
    input  chkReg1, chkReg2, chkFloat,
    output busy
  );

  modport master (
    output intValid, intDest, intData,
    input  intReady,
    output fpValid, fpDest, fpData,
    input  fpReady,
    input  regWrite, float, writeReg, writeData,
    output issueValid, issueDest, issueFloat,
    output chkReg1, chkReg2, chkFloat,
    input  busy
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// Register file write-side initiator: round-robin arbitration of integer and FPU
// results, a small FIFO, a registered write port and a per-register pending scoreboard.
module reg_writeback_unit #(
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  reg_writeback_unit_if.slave bus
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              bank;
    logic [4:0]        dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           queue [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             last_grant;   // 1 = FPU granted last
  logic [1:0][31:0] pending;
  logic [1:0][31:0] pending_next;

  logic   grant_int;
  logic   grant_fp;
  logic   not_full;
  logic   accept;
  logic   keep;
  logic   do_pop;
  logic   do_push;
  entry_t offer;
  entry_t head;

  // Arbitration: on a tie the source that lost last time wins.
  always_comb begin
    grant_int = bus.intValid && (!bus.fpValid || last_grant);
    grant_fp  = bus.fpValid && (!bus.intValid || !last_grant);
    not_full  = (count < CNT_W'(DEPTH));
  end

  assign bus.intReady = grant_int && not_full;
  assign bus.fpReady  = grant_fp && not_full;

  always_comb begin
    accept = bus.intReady || bus.fpReady;
    offer  = '0;
    if (bus.fpReady) begin
      offer.bank = 1'b1;
      offer.dest = bus.fpDest;
      offer.data = bus.fpData;
    end else begin
      offer.bank = 1'b0;
      offer.dest = bus.intDest;
      offer.data = bus.intData;
    end
    // Writes to register 0 are swallowed: no queue, no bypass.
    keep    = accept && (offer.dest != 5'd0);
    do_pop  = (count != '0);
    do_push = keep && do_pop;
    head    = queue[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) queue[wr_ptr] <= offer;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
    end else begin
      if (accept) last_grant <= bus.fpReady;
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop) count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Write port: queue head first, otherwise bypass the accepted offer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.regWrite  <= 1'b0;
      bus.float     <= 1'b0;
      bus.writeReg  <= '0;
      bus.writeData <= '0;
    end else if (do_pop) begin
      bus.regWrite  <= 1'b1;
      bus.float     <= head.bank;
      bus.writeReg  <= head.dest;
      bus.writeData <= head.data;
    end else if (keep) begin
      bus.regWrite  <= 1'b1;
      bus.float     <= offer.bank;
      bus.writeReg  <= offer.dest;
      bus.writeData <= offer.data;
    end else begin
      bus.regWrite  <= 1'b0;
    end
  end

  // Scoreboard: clear on the commit edge, a new issue to the same register wins.
  always_comb begin
    pending_next = pending;
    if (bus.regWrite) pending_next[bus.float][bus.writeReg] = 1'b0;
    if (bus.issueValid && (bus.issueDest != 5'd0))
      pending_next[bus.issueFloat][bus.issueDest] = 1'b1;
    pending_next[0][0] = 1'b0;
    pending_next[1][0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_next;
  end

  assign bus.busy = pending[bus.chkFloat][bus.chkReg1] | pending[bus.chkFloat][bus.chkReg2];

endmodule
